// File: rtl/aha_clk_req_sequencer.sv
// Clock-request sequencer: gates one clock domain, switches its divider select and reapplies the requested gate.
// Optional macro AHA_CLK_REQ_SEL_CHECK_EN rejects selects above 5 through the REJECT state.
module aha_clk_req_sequencer #(
  parameter int         SETTLE_CYCLES = 8,
  parameter logic [2:0] RESET_SELECT  = 3'd1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [2:0] REQ_SELECT,
  input  logic       REQ_GATE,
  output logic       CLK_GATE,
  output logic [2:0] CLK_SELECT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE_OFF = 3'd1,
    WAIT_OFF = 3'd2,
    SWITCH   = 3'd3,
    WAIT_SW  = 3'd4,
    APPLY    = 3'd5,
    REJECT   = 3'd6
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic [2:0] sel_cap_r;
  logic [2:0] sel_cap_s;
  logic       gate_cap_r;
  logic       gate_cap_s;
  logic       gate_r;
  logic       gate_s;
  logic [2:0] sel_r;
  logic [2:0] sel_s;
  logic       ready_r;
  logic       busy_r;
  logic       done_r;
  logic       accept_s;

  // REQ_READY is only ever high while the registered state is IDLE
  assign accept_s = REQ_VALID && ready_r && (state_r == IDLE);

  // Next-state, settle counter and captured-request logic
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    sel_cap_s  = sel_cap_r;
    gate_cap_s = gate_cap_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          sel_cap_s  = REQ_SELECT;
          gate_cap_s = REQ_GATE;
`ifdef AHA_CLK_REQ_SEL_CHECK_EN
          if (REQ_SELECT > 3'd5) begin
            state_s = REJECT;
          end else if (REQ_SELECT == sel_r) begin
            state_s = APPLY;
          end else begin
            state_s = GATE_OFF;
          end
`else
          if (REQ_SELECT == sel_r) begin
            state_s = APPLY;
          end else begin
            state_s = GATE_OFF;
          end
`endif
        end else begin
          state_s = IDLE;
        end
      end
      GATE_OFF: begin
        state_s = WAIT_OFF;
        cnt_s   = SETTLE_LOAD;
      end
      WAIT_OFF: begin
        // A count of 1 or less ends the wait, so a zero setting still behaves as 1
        if (cnt_r <= 8'd1) begin
          state_s = SWITCH;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      SWITCH: begin
        state_s = WAIT_SW;
        cnt_s   = SETTLE_LOAD;
      end
      WAIT_SW: begin
        if (cnt_r <= 8'd1) begin
          state_s = APPLY;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      APPLY: begin
        state_s = IDLE;
      end
`ifdef AHA_CLK_REQ_SEL_CHECK_EN
      REJECT: begin
        state_s = IDLE;
      end
`endif
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Clock-controller outputs decoded from the state being entered, so they register with it
  always_comb begin
    gate_s = gate_r;
    sel_s  = sel_r;
    case (state_s)
      GATE_OFF, WAIT_OFF, WAIT_SW: begin
        gate_s = 1'b1;
      end
      SWITCH: begin
        gate_s = 1'b1;
        sel_s  = sel_cap_r;
      end
      APPLY: begin
        gate_s = gate_cap_s;
      end
      default: begin
        gate_s = gate_r;
        sel_s  = sel_r;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      sel_cap_r  <= RESET_SELECT;
      gate_cap_r <= 1'b0;
      gate_r     <= 1'b0;
      sel_r      <= RESET_SELECT;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      sel_cap_r  <= sel_cap_s;
      gate_cap_r <= gate_cap_s;
      gate_r     <= gate_s;
      sel_r      <= sel_s;
      ready_r    <= (state_s == IDLE);
      busy_r     <= (state_s != IDLE);
      done_r     <= (state_s == APPLY);
    end
  end

`ifdef AHA_CLK_REQ_SEL_CHECK_EN
  logic err_r;

  // Rejection pulse register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_s == REJECT);
    end
  end

  assign ERR = err_r;
`else
  assign ERR = 1'b0;
`endif

  assign REQ_READY  = ready_r;
  assign CLK_GATE   = gate_r;
  assign CLK_SELECT = sel_r;
  assign BUSY       = busy_r;
  assign DONE       = done_r;

endmodule

// File: tb/tb_aha_clk_req_sequencer.sv
// Directed bench for aha_clk_req_sequencer with SETTLE_CYCLES=8 and RESET_SELECT=1.
module tb_aha_clk_req_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [2:0] REQ_SELECT;
  logic       REQ_GATE;
  logic       CLK_GATE;
  logic [2:0] CLK_SELECT;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int n_checks = 0;
  int n_fail   = 0;

  // Cycle offsets after accept for SETTLE_CYCLES=8 with a select change
  localparam int T_SEL  = 10;
  localparam int T_DONE = 19;
  localparam int T_RDY  = 20;

  aha_clk_req_sequencer #(
    .SETTLE_CYCLES(8),
    .RESET_SELECT (3'd1)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_SELECT(REQ_SELECT),
    .REQ_GATE  (REQ_GATE),
    .CLK_GATE  (CLK_GATE),
    .CLK_SELECT(CLK_SELECT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Follows a select-changing request from cycle 1 to cycle 20 after accept; at cycle 1 the
  // request inputs are replaced with the given values (used to hold a second request).
  task automatic expect_switch(input string tag, input logic [2:0] old_sel, input logic [2:0] new_sel,
                               input logic new_gate, input logic nxt_valid, input logic [2:0] nxt_sel,
                               input logic nxt_gate);
    logic       gate_exp;
    logic [2:0] sel_exp;
    for (int k = 1; k <= T_RDY; k++) begin
      tick();
      if (k == 1) begin
        REQ_VALID  = nxt_valid;
        REQ_SELECT = nxt_sel;
        REQ_GATE   = nxt_gate;
      end
      gate_exp = (k >= T_DONE) ? new_gate : 1'b1;
      sel_exp  = (k >= T_SEL) ? new_sel : old_sel;
      check_eq($sformatf("%s gate c%0d", tag, k), {7'd0, CLK_GATE}, {7'd0, gate_exp});
      check_eq($sformatf("%s sel c%0d", tag, k), {5'd0, CLK_SELECT}, {5'd0, sel_exp});
      check_eq($sformatf("%s done c%0d", tag, k), {7'd0, DONE}, (k == T_DONE) ? 8'd1 : 8'd0);
      check_eq($sformatf("%s ready c%0d", tag, k), {7'd0, REQ_READY}, (k == T_RDY) ? 8'd1 : 8'd0);
      check_eq($sformatf("%s busy c%0d", tag, k), {7'd0, BUSY}, (k <= T_DONE) ? 8'd1 : 8'd0);
      check_eq($sformatf("%s err c%0d", tag, k), {7'd0, ERR}, 8'd0);
    end
  endtask

  initial begin
    RESET      = 1'b1;
    REQ_VALID  = 1'b0;
    REQ_SELECT = 3'd0;
    REQ_GATE   = 1'b0;
    repeat (3) tick();
    check_eq("rst gate", {7'd0, CLK_GATE}, 8'd0);
    check_eq("rst sel", {5'd0, CLK_SELECT}, 8'd1);
    check_eq("rst ready", {7'd0, REQ_READY}, 8'd0);
    check_eq("rst busy", {7'd0, BUSY}, 8'd0);
    check_eq("rst done", {7'd0, DONE}, 8'd0);
    check_eq("rst err", {7'd0, ERR}, 8'd0);

    RESET = 1'b0;
    tick();
    check_eq("rel ready", {7'd0, REQ_READY}, 8'd1);
    check_eq("rel gate", {7'd0, CLK_GATE}, 8'd0);
    check_eq("rel sel", {5'd0, CLK_SELECT}, 8'd1);
    check_eq("rel busy", {7'd0, BUSY}, 8'd0);

    // Same select: straight to APPLY
    REQ_VALID  = 1'b1;
    REQ_SELECT = 3'd1;
    REQ_GATE   = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    check_eq("same gate c1", {7'd0, CLK_GATE}, 8'd1);
    check_eq("same done c1", {7'd0, DONE}, 8'd1);
    check_eq("same sel c1", {5'd0, CLK_SELECT}, 8'd1);
    check_eq("same busy c1", {7'd0, BUSY}, 8'd1);
    check_eq("same ready c1", {7'd0, REQ_READY}, 8'd0);
    tick();
    check_eq("same done c2", {7'd0, DONE}, 8'd0);
    check_eq("same ready c2", {7'd0, REQ_READY}, 8'd1);
    check_eq("same gate c2", {7'd0, CLK_GATE}, 8'd1);
    check_eq("same sel c2", {5'd0, CLK_SELECT}, 8'd1);
    check_eq("same busy c2", {7'd0, BUSY}, 8'd0);

    // Full switch 1 -> 3, final gate running
    REQ_VALID  = 1'b1;
    REQ_SELECT = 3'd3;
    REQ_GATE   = 1'b0;
    expect_switch("sw13", 3'd1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0);

    // Request A (3 -> 0) with request B (select 2, gate 1) held valid throughout A
    REQ_VALID  = 1'b1;
    REQ_SELECT = 3'd0;
    REQ_GATE   = 1'b0;
    expect_switch("holdA", 3'd3, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1);
    expect_switch("holdB", 3'd0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0);

    // Reset during cycle 5 of a 2 -> 4 switch
    REQ_VALID  = 1'b1;
    REQ_SELECT = 3'd4;
    REQ_GATE   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      REQ_VALID = 1'b0;
      check_eq($sformatf("abort gate c%0d", k), {7'd0, CLK_GATE}, 8'd1);
      check_eq($sformatf("abort sel c%0d", k), {5'd0, CLK_SELECT}, 8'd2);
      check_eq($sformatf("abort done c%0d", k), {7'd0, DONE}, 8'd0);
    end
    RESET = 1'b1;
    tick();
    check_eq("abort rst gate", {7'd0, CLK_GATE}, 8'd0);
    check_eq("abort rst sel", {5'd0, CLK_SELECT}, 8'd1);
    check_eq("abort rst done", {7'd0, DONE}, 8'd0);
    check_eq("abort rst err", {7'd0, ERR}, 8'd0);
    check_eq("abort rst ready", {7'd0, REQ_READY}, 8'd0);
    check_eq("abort rst busy", {7'd0, BUSY}, 8'd0);
    RESET = 1'b0;
    tick();
    check_eq("abort rel ready", {7'd0, REQ_READY}, 8'd1);
    check_eq("abort rel done", {7'd0, DONE}, 8'd0);
    check_eq("abort rel gate", {7'd0, CLK_GATE}, 8'd0);

    // Out-of-range select 7 from select 1
    REQ_VALID  = 1'b1;
    REQ_SELECT = 3'd7;
    REQ_GATE   = 1'b0;
`ifdef AHA_CLK_REQ_SEL_CHECK_EN
    tick();
    REQ_VALID = 1'b0;
    check_eq("rej err c1", {7'd0, ERR}, 8'd1);
    check_eq("rej gate c1", {7'd0, CLK_GATE}, 8'd0);
    check_eq("rej sel c1", {5'd0, CLK_SELECT}, 8'd1);
    check_eq("rej done c1", {7'd0, DONE}, 8'd0);
    check_eq("rej ready c1", {7'd0, REQ_READY}, 8'd0);
    tick();
    check_eq("rej err c2", {7'd0, ERR}, 8'd0);
    check_eq("rej ready c2", {7'd0, REQ_READY}, 8'd1);
    check_eq("rej done c2", {7'd0, DONE}, 8'd0);
    check_eq("rej gate c2", {7'd0, CLK_GATE}, 8'd0);
    check_eq("rej sel c2", {5'd0, CLK_SELECT}, 8'd1);
`else
    expect_switch("sel7", 3'd1, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aha_clk_req_sequencer.md
AHA_CLK_REQ_SEQUENCER -- requirements
Module: aha_clk_req_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, settle wait in CLK cycles applied around each select change; legal range 1..255.
REQ-002 SHALL have parameter RESET_SELECT, default 3'd1, CLK_SELECT value driven out of reset.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port REQ_VALID  input  1  request valid.
REQ-006 SHALL have port REQ_READY  output  1  sequencer can accept a request.
REQ-007 SHALL have port REQ_SELECT  input  3  requested divider select: 0=/1, 1=/2, 2=/4, 3=/8, 4=/16, 5=/32.
REQ-008 SHALL have port REQ_GATE  input  1  requested final gate state: 1=clock stopped, 0=running.
REQ-009 SHALL have port CLK_GATE  output  1  gate request to the clock controller for one domain.
REQ-010 SHALL have port CLK_SELECT  output  3  divider select to the clock controller for the same domain.
REQ-011 SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse on request completion.
REQ-013 SHALL have port ERR  output  1  one-cycle pulse on rejected request; tied 0 when AHA_CLK_REQ_SEL_CHECK_EN is undefined.

Function
REQ-014 SHALL implement FSM states IDLE, GATE_OFF, WAIT_OFF, SWITCH, WAIT_SW, APPLY, and REJECT.
REQ-015 SHALL assert REQ_READY only in IDLE, and SHALL accept on a REQ_VALID&&REQ_READY edge, capturing REQ_SELECT and REQ_GATE.
REQ-016 SHALL ignore REQ_VALID while not IDLE, with no queueing; requesters hold request fields until accepted.
REQ-017 SHALL, when the captured select equals the current CLK_SELECT, go IDLE->APPLY: CLK_GATE takes the captured gate 1 cycle after accept, CLK_SELECT is unchanged, and the GATE_OFF, WAIT_OFF, SWITCH and WAIT_SW states are skipped.
REQ-018 SHALL, when the select differs, drive CLK_GATE=1 in GATE_OFF 1 cycle after accept.
REQ-019 SHALL, in WAIT_OFF, count SETTLE_CYCLES cycles with an 8-bit down-counter, then go to SWITCH.
REQ-020 SHALL update CLK_SELECT in SWITCH exactly SETTLE_CYCLES+1 cycles after CLK_GATE rises, with CLK_GATE held 1 throughout.
REQ-021 SHALL wait SETTLE_CYCLES cycles in WAIT_SW, then enter APPLY.
REQ-022 SHALL, in APPLY, drive CLK_GATE to the captured gate SETTLE_CYCLES+1 cycles after the CLK_SELECT change.
REQ-023 SHALL pulse DONE in the same cycle CLK_GATE takes its final value, then return to IDLE with REQ_READY=1 on the next cycle.
REQ-024 SHALL give, for SETTLE_CYCLES=8 with a select change: accept at cycle 0, CLK_GATE=1 at 1, CLK_SELECT new at 10, final gate and DONE at 19, REQ_READY at 20.
REQ-025 SHALL change CLK_SELECT only while CLK_GATE=1, and SHALL never change CLK_SELECT and CLK_GATE in the same cycle.
REQ-026 SHALL keep CLK_GATE and CLK_SELECT stable in IDLE.
REQ-027 SHALL never assert DONE and ERR in the same cycle.

Reset
REQ-028 SHALL, on RESET=1 at an edge, drive state=IDLE, counter=0, CLK_GATE=0, CLK_SELECT=RESET_SELECT, BUSY=0, DONE=0, ERR=0, and REQ_READY=0 while RESET is high.
REQ-029 SHALL make REQ_READY=1 in the first cycle after RESET deasserts.
REQ-030 SHALL, on reset mid-sequence, abort the sequence with no DONE or ERR; outputs take reset values at that edge.

Configuration
REQ-031 SHALL, with AHA_CLK_REQ_SEL_CHECK_EN defined, accept a request with REQ_SELECT>5, enter REJECT, leave CLK_GATE and CLK_SELECT unchanged, pulse ERR 1 cycle after accept, raise no DONE, and restore REQ_READY the next cycle.
REQ-032 SHALL, with AHA_CLK_REQ_SEL_CHECK_EN undefined, omit the REJECT logic, tie ERR to 0, and sequence values 6 and 7 like any other select.

Verification
REQ-033 SHALL cover: reset release with SETTLE_CYCLES=8 -> CLK_GATE=0, CLK_SELECT=1, REQ_READY=1 at cycle 1 after release.
REQ-034 SHALL cover: request select=3, gate=0 from select=1 -> CLK_GATE=1 at +1, CLK_SELECT=3 at +10, CLK_GATE=0 and DONE at +19, REQ_READY at +20.
REQ-035 SHALL cover: request select=1, gate=1 while select=1 -> CLK_GATE=1 and DONE at +1, CLK_SELECT never toggles.
REQ-036 SHALL cover: second REQ_VALID held during BUSY -> ignored until IDLE, then accepted on the REQ_READY cycle.
REQ-037 SHALL cover: RESET at cycle +5 of a switch -> CLK_GATE=0, CLK_SELECT=RESET_SELECT next cycle, no DONE.
REQ-038 SHALL cover: with AHA_CLK_REQ_SEL_CHECK_EN, request select=7 -> ERR pulse at +1, outputs unchanged, no DONE; without the macro, CLK_SELECT=7 at +10.
